// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM state type and width constants for the fully-connected layer controller
package fc_pkg;
    localparam int FC_DATA_WIDTH = 16;
    localparam int FC_ACC_FACTOR = 4;
    localparam int FC_ACC_WIDTH  = FC_ACC_FACTOR * FC_DATA_WIDTH;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FEED, S_DRAIN, S_DONE} fc_state_t;
    // Address width for a memory of n entries; a single-entry memory still gets one bit
    function automatic int fc_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fc_addr_gen.sv
// fc_addr_gen: neuron/input counters and node, weight and bias read addresses
module fc_addr_gen import fc_pkg::*; #(
    parameter int IN_NODE  = 8,
    parameter int OUT_NODE = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clr_i,
    input  logic                                   inc_i,
    input  logic                                   clr_j,
    input  logic                                   inc_j,
    output logic [fc_addr_w(IN_NODE)-1:0]          node_addr,
    output logic [fc_addr_w(IN_NODE*OUT_NODE)-1:0] wegt_addr,
    output logic [fc_addr_w(OUT_NODE)-1:0]         bias_addr,
    output logic                                   last_i,
    output logic                                   last_j
);
    localparam int NAW = fc_addr_w(IN_NODE);
    localparam int WAW = fc_addr_w(IN_NODE * OUT_NODE);
    localparam int BAW = fc_addr_w(OUT_NODE);
    logic [BAW-1:0] i;
    logic [NAW-1:0] j;
    // i walks neurons across a layer, j walks inputs within a neuron; both hold at their bound
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i <= '0;
            j <= '0;
        end else begin
            i <= clr_i ? '0 : (inc_i && !last_i) ? i + 1'b1 : i;
            j <= clr_j ? '0 : (inc_j && !last_j) ? j + 1'b1 : j;
        end
    end
    assign last_i    = i == BAW'(OUT_NODE - 1);
    assign last_j    = j == NAW'(IN_NODE - 1);
    assign node_addr = j;
    assign bias_addr = i;
    assign wegt_addr = WAW'(i) * WAW'(IN_NODE) + WAW'(j);
endmodule

// File: rtl/fully_connected_ctrl.sv
// fully_connected_ctrl: streams node/weight/bias reads into a MAC core one neuron at a time
module fully_connected_ctrl import fc_pkg::*; #(
    parameter int IN_DATA_WIDTH = FC_DATA_WIDTH,
    parameter int IN_NODE       = 8,
    parameter int OUT_NODE      = 4
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     i_start,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_node_rd_en,
    output logic [fc_addr_w(IN_NODE)-1:0]            o_node_addr,
    input  logic [IN_DATA_WIDTH-1:0]                 i_node_rdata,
    output logic                                     o_wegt_rd_en,
    output logic [fc_addr_w(IN_NODE*OUT_NODE)-1:0]   o_wegt_addr,
    input  logic [IN_DATA_WIDTH-1:0]                 i_wegt_rdata,
    output logic                                     o_bias_rd_en,
    output logic [fc_addr_w(OUT_NODE)-1:0]           o_bias_addr,
    input  logic [IN_DATA_WIDTH-1:0]                 i_bias_rdata,
    output logic                                     o_core_run,
    output logic                                     o_core_valid,
    output logic [IN_DATA_WIDTH-1:0]                 o_core_node,
    output logic [IN_DATA_WIDTH-1:0]                 o_core_wegt,
    output logic [IN_DATA_WIDTH-1:0]                 o_core_bias,
    input  logic                                     i_core_valid,
    input  logic [FC_ACC_FACTOR*IN_DATA_WIDTH-1:0]   i_core_result,
    output logic                                     o_res_valid,
    output logic [fc_addr_w(OUT_NODE)-1:0]           o_res_idx,
    output logic [FC_ACC_FACTOR*IN_DATA_WIDTH-1:0]   o_res_data,
    output logic                                     o_err
);
    fc_state_t state;
    logic      last_i, last_j, bias_sel, last_d1, last_d2, accept, capture;
    assign accept  = state == S_IDLE && i_start;
    assign capture = state == S_DRAIN && last_d2;
    fc_addr_gen #(
        .IN_NODE  (IN_NODE),
        .OUT_NODE (OUT_NODE)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (accept),
        .inc_i     (capture),
        .clr_j     (state == S_RUN),
        .inc_j     (state == S_FEED),
        .node_addr (o_node_addr),
        .wegt_addr (o_wegt_addr),
        .bias_addr (o_bias_addr),
        .last_i    (last_i),
        .last_j    (last_j)
    );
    // Layer sequencer: state plus every registered control and result output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_core_run   <= 1'b0;
            o_node_rd_en <= 1'b0;
            o_wegt_rd_en <= 1'b0;
            o_bias_rd_en <= 1'b0;
            o_res_valid  <= 1'b0;
            o_res_idx    <= '0;
            o_res_data   <= '0;
            o_err        <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_core_run   <= 1'b0;
            o_bias_rd_en <= 1'b0;
            o_res_valid  <= 1'b0;
            case (state)
                S_IDLE: if (i_start) begin
                    state      <= S_RUN;
                    o_busy     <= 1'b1;
                    o_core_run <= 1'b1;
                    o_err      <= 1'b0;
                end
                S_RUN: begin
                    state        <= S_FEED;
                    o_node_rd_en <= 1'b1;
                    o_wegt_rd_en <= 1'b1;
                    o_bias_rd_en <= 1'b1;
                end
                S_FEED: if (last_j) begin
                    state        <= S_DRAIN;
                    o_node_rd_en <= 1'b0;
                    o_wegt_rd_en <= 1'b0;
                end
                S_DRAIN: if (last_d2) begin
                    o_res_valid <= 1'b1;
                    o_res_idx   <= o_bias_addr;
                    o_res_data  <= i_core_result;
                    o_err       <= o_err || !i_core_valid;
                    state       <= last_i ? S_DONE : S_RUN;
                    o_done      <= last_i;
                    o_core_run  <= !last_i;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    // Align beat valid, bias select and last-beat flag with the one-cycle memory and core latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_core_valid <= 1'b0;
            bias_sel     <= 1'b0;
            last_d1      <= 1'b0;
            last_d2      <= 1'b0;
        end else begin
            o_core_valid <= o_node_rd_en;
            bias_sel     <= o_bias_rd_en;
            last_d1      <= o_node_rd_en && last_j;
            last_d2      <= last_d1;
        end
    end
    assign o_core_node = o_core_valid ? i_node_rdata : '0;
    assign o_core_wegt = o_core_valid ? i_wegt_rdata : '0;
    assign o_core_bias = bias_sel ? i_bias_rdata : '0;
endmodule

// File: tb/tb_fully_connected_ctrl.sv
// tb_fully_connected_ctrl: randomized layers on a 4x4 and a 1x1 controller against an arithmetic reference
module tb_fully_connected_ctrl;
    localparam int N   = 4;
    localparam int M   = 4;
    localparam int LAT = M * (N + 3) + 1;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- 4x4 instance ----------------
    logic        start, busy, done, node_rd_en, wegt_rd_en, bias_rd_en;
    logic [1:0]  node_addr, bias_addr, res_idx;
    logic [3:0]  wegt_addr;
    logic [15:0] node_rdata, wegt_rdata, bias_rdata, core_node, core_wegt, core_bias;
    logic        core_run, core_valid, core_valid_in, res_valid, err, core_v_q, drop_now;
    logic [63:0] core_result, res_data;
    logic signed [63:0] acc;
    logic [15:0] node_mem [N];
    logic [15:0] wegt_mem [N*M];
    logic [15:0] bias_mem [M];

    fully_connected_ctrl #(.IN_DATA_WIDTH(16), .IN_NODE(N), .OUT_NODE(M)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_node_rd_en(node_rd_en), .o_node_addr(node_addr), .i_node_rdata(node_rdata),
        .o_wegt_rd_en(wegt_rd_en), .o_wegt_addr(wegt_addr), .i_wegt_rdata(wegt_rdata),
        .o_bias_rd_en(bias_rd_en), .o_bias_addr(bias_addr), .i_bias_rdata(bias_rdata),
        .o_core_run(core_run), .o_core_valid(core_valid), .o_core_node(core_node),
        .o_core_wegt(core_wegt), .o_core_bias(core_bias), .i_core_valid(core_valid_in),
        .i_core_result(core_result), .o_res_valid(res_valid), .o_res_idx(res_idx),
        .o_res_data(res_data), .o_err(err)
    );

    always @(posedge clk) begin
        node_rdata <= node_rd_en ? node_mem[node_addr] : 16'($urandom);
        wegt_rdata <= wegt_rd_en ? wegt_mem[wegt_addr] : 16'($urandom);
        bias_rdata <= bias_rd_en ? bias_mem[bias_addr] : 16'($urandom);
        if (core_run) acc <= 64'sd0;
        else if (core_valid) acc <= acc + $signed(core_node) * $signed(core_wegt) + $signed(core_bias);
        core_v_q <= core_valid;
    end
    assign core_result   = acc;
    assign core_valid_in = core_v_q && !drop_now;

    // ---------------- 1x1 instance ----------------
    logic        b_start, b_busy, b_done, b_node_rd_en, b_wegt_rd_en, b_bias_rd_en;
    logic [0:0]  b_node_addr, b_wegt_addr, b_bias_addr, b_res_idx;
    logic [15:0] b_node_rdata, b_wegt_rdata, b_bias_rdata, b_core_node, b_core_wegt, b_core_bias;
    logic        b_core_run, b_core_valid, b_core_v_q, b_res_valid, b_err;
    logic [63:0] b_res_data;
    logic signed [63:0] b_acc;
    logic [15:0] b_node, b_wegt, b_bias;

    fully_connected_ctrl #(.IN_DATA_WIDTH(16), .IN_NODE(1), .OUT_NODE(1)) u_dut_1x1 (
        .clk(clk), .reset_n(reset_n), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
        .o_node_rd_en(b_node_rd_en), .o_node_addr(b_node_addr), .i_node_rdata(b_node_rdata),
        .o_wegt_rd_en(b_wegt_rd_en), .o_wegt_addr(b_wegt_addr), .i_wegt_rdata(b_wegt_rdata),
        .o_bias_rd_en(b_bias_rd_en), .o_bias_addr(b_bias_addr), .i_bias_rdata(b_bias_rdata),
        .o_core_run(b_core_run), .o_core_valid(b_core_valid), .o_core_node(b_core_node),
        .o_core_wegt(b_core_wegt), .o_core_bias(b_core_bias), .i_core_valid(b_core_v_q),
        .i_core_result(b_acc), .o_res_valid(b_res_valid), .o_res_idx(b_res_idx),
        .o_res_data(b_res_data), .o_err(b_err)
    );

    always @(posedge clk) begin
        b_node_rdata <= (b_node_rd_en && b_node_addr == 1'b0) ? b_node : 16'($urandom);
        b_wegt_rdata <= (b_wegt_rd_en && b_wegt_addr == 1'b0) ? b_wegt : 16'($urandom);
        b_bias_rdata <= (b_bias_rd_en && b_bias_addr == 1'b0) ? b_bias : 16'($urandom);
        if (b_core_run) b_acc <= 64'sd0;
        else if (b_core_valid) b_acc <= b_acc + $signed(b_core_node) * $signed(b_core_wegt) + $signed(b_core_bias);
        b_core_v_q <= b_core_valid;
    end

    task automatic check_zero(input string pfx);
        check({pfx, "_ctl"}, {busy, done, core_run, core_valid, node_rd_en, wegt_rd_en, bias_rd_en, res_valid, err}, 0);
        check({pfx, "_addr"}, {node_addr, wegt_addr, bias_addr, res_idx}, 0);
        check({pfx, "_res_data"}, res_data, 0);
        check({pfx, "_core_ops"}, {core_node, core_wegt, core_bias}, 0);
    endtask

    task automatic mem_rand();
        for (int r = 0; r < N * M; r++) wegt_mem[r] = 16'($urandom);
        for (int r = 0; r < N; r++) node_mem[r] = 16'($urandom);
        for (int r = 0; r < M; r++) bias_mem[r] = 16'($urandom);
    endtask

    // Called on a falling edge; start is seen at the next rising edge, so cycle k=1 is the first busy cycle.
    // Neuron n occupies cycles 1+n*(N+3) .. (n+1)*(N+3); its result shows in the cycle after that.
    task automatic run_layer(input bit hold, input int drop, input int rst_at);
        longint exp_res [M];
        int ph, n;
        for (int r = 0; r < M; r++) begin
            exp_res[r] = longint'($signed(bias_mem[r]));
            for (int c = 0; c < N; c++)
                exp_res[r] += longint'($signed(node_mem[c])) * longint'($signed(wegt_mem[r*N+c]));
        end
        start = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) start = hold;
            n  = (k - 1) / (N + 3);
            ph = (k - 1) % (N + 3);
            check("busy", busy, k <= LAT);
            check("done", done, k == LAT);
            check("core_run", core_run, k < LAT && ph == 0);
            check("node_rd_en", node_rd_en, k < LAT && ph >= 1 && ph <= N);
            check("bias_rd_en", bias_rd_en, k < LAT && ph == 1);
            check("run_and_valid", core_run && core_valid, 0);
            check("err", err, drop >= 0 && k > (drop + 1) * (N + 3));
            check("res_valid", res_valid, k > 1 && ph == 0);
            if (k < LAT && ph >= 1 && ph <= N) begin
                check("node_addr", node_addr, ph - 1);
                check("wegt_addr", wegt_addr, n * N + ph - 1);
                if (ph == 1) check("bias_addr", bias_addr, n);
            end
            if (k > 1 && ph == 0) begin
                check("res_idx", res_idx, n - 1);
                check("res_data", res_data, exp_res[n-1]);
            end
            drop_now = drop >= 0 && k == (drop + 1) * (N + 3);
            if (k == rst_at) begin
                #2 reset_n = 1'b0;
                #1 check_zero("midrst");
                @(negedge clk);
                reset_n  = 1'b1;
                drop_now = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_b(input logic [15:0] nd, input logic [15:0] wt, input logic [15:0] bs);
        longint e;
        b_node = nd;
        b_wegt = wt;
        b_bias = bs;
        e = longint'($signed(nd)) * longint'($signed(wt)) + longint'($signed(bs));
        b_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) b_start = 1'b0;
            check("b_busy", b_busy, k <= 5);
            check("b_core_run", b_core_run, k == 1);
            check("b_node_rd_en", b_node_rd_en, k == 2);
            check("b_res_valid", b_res_valid, k == 5);
            check("b_done", b_done, k == 5);
            if (k == 5) begin
                check("b_res_idx", b_res_idx, 0);
                check("b_res_data", b_res_data, e);
            end
        end
        check("b_err", b_err, 0);
    endtask

    initial begin
        int seen;
        reset_n  = 1'b0;
        start    = 1'b0;
        b_start  = 1'b0;
        drop_now = 1'b0;
        b_node   = '0;
        b_wegt   = '0;
        b_bias   = '0;
        mem_rand();
        repeat (2) @(negedge clk);
        check_zero("por");
        check("b_por", {b_busy, b_done, b_res_valid, b_err, b_core_run, b_core_valid, b_res_data}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        // row r weights all r+1, nodes all 2, no bias -> 8,16,24,32
        for (int r = 0; r < M; r++) begin
            bias_mem[r] = 16'd0;
            for (int c = 0; c < N; c++) wegt_mem[r*N+c] = 16'(r + 1);
        end
        for (int c = 0; c < N; c++) node_mem[c] = 16'd2;
        run_layer(1'b0, -1, -1);
        // nodes 1..4, unit weights, bias 5 -> 15 for every neuron
        for (int r = 0; r < M; r++) begin
            bias_mem[r] = 16'd5;
            for (int c = 0; c < N; c++) wegt_mem[r*N+c] = 16'd1;
        end
        for (int c = 0; c < N; c++) node_mem[c] = 16'(c + 1);
        run_layer(1'b0, -1, -1);
        repeat (3) begin
            mem_rand();
            run_layer(1'b0, -1, -1);
        end
        // start held high: back-to-back layers, each only after the previous one idles
        mem_rand();
        run_layer(1'b1, -1, -1);
        mem_rand();
        run_layer(1'b1, -1, -1);
        mem_rand();
        run_layer(1'b0, -1, -1);
        // missing core valid on neuron 1, then the error clears on the following start
        mem_rand();
        run_layer(1'b0, 1, -1);
        mem_rand();
        run_layer(1'b0, -1, -1);
        // reset in the middle of neuron 2's feed, quiet afterwards, then a clean layer
        mem_rand();
        run_layer(1'b0, -1, 2 * (N + 3) + 2);
        seen = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk);
            seen += int'(res_valid) + int'(done) + int'(busy);
        end
        check("quiet_after_rst", seen, 0);
        mem_rand();
        run_layer(1'b0, -1, -1);
        // single input, single neuron
        run_b(16'hFFFD, 16'd7, 16'd2);
        repeat (3) run_b(16'($urandom), 16'($urandom), 16'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
